// File: rtl/cpu_pkg.sv
// Shared CPU types: control bundle, decoded instruction bundle and RV32 field encodings.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_SUB  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_XOR = 3'd5
  } alu_op_t;

  typedef enum logic {
    SRC_A_RS1 = 1'b0,
    SRC_A_PC  = 1'b1
  } src_a_sel_t;

  typedef enum logic {
    SRC_B_RS2 = 1'b0,
    SRC_B_IMM = 1'b1
  } src_b_sel_t;

  typedef struct packed {
    alu_op_t    alu_op;
    src_a_sel_t src_a_sel;
    src_b_sel_t src_b_sel;
    logic       reg_write;
  } control_signals_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    control_signals_t ctrl;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [XLEN-1:0]  imm;
    logic             illegal;
  } decoded_bundle_t;

  localparam control_signals_t CTRL_RESET = '{
    alu_op:    ALU_NOP,
    src_a_sel: SRC_A_RS1,
    src_b_sel: SRC_B_RS2,
    reg_write: 1'b0
  };

  localparam decoded_bundle_t BUNDLE_RESET = '{
    pc:      '0,
    ctrl:    CTRL_RESET,
    rs1:     '0,
    rs2:     '0,
    rd:      '0,
    imm:     '0,
    illegal: 1'b0
  };

endpackage

// File: rtl/decode_logic.sv
// Combinational RV32 ALU-subset decoder: instruction word to control, register indices,
// immediate and illegal flag.
module decode_logic
  import cpu_pkg::*;
(
  input  logic [31:0]            instr,
  output control_signals_t       ctrl,
  output logic [4:0]             rs1,
  output logic [4:0]             rs2,
  output logic [4:0]             rd,
  output logic [cpu_pkg::XLEN-1:0] imm,
  output logic                   illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  logic       is_imm;
  alu_op_t    alu_op;
  src_b_sel_t src_b_sel;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    legal     = 1'b0;
    is_imm    = 1'b0;
    alu_op    = ALU_NOP;
    src_b_sel = SRC_B_RS2;
    case (opcode)
      OPCODE_OP: begin
        case ({funct7, funct3})
          {FUNCT7_BASE, FUNCT3_ADD_SUB}: begin legal = 1'b1; alu_op = ALU_ADD; end
          {FUNCT7_SUB,  FUNCT3_ADD_SUB}: begin legal = 1'b1; alu_op = ALU_SUB; end
          {FUNCT7_BASE, FUNCT3_AND}:     begin legal = 1'b1; alu_op = ALU_AND; end
          {FUNCT7_BASE, FUNCT3_OR}:      begin legal = 1'b1; alu_op = ALU_OR;  end
          {FUNCT7_BASE, FUNCT3_XOR}:     begin legal = 1'b1; alu_op = ALU_XOR; end
          default: ;
        endcase
      end
      OPCODE_OP_IMM: begin
        is_imm    = 1'b1;
        src_b_sel = SRC_B_IMM;
        case (funct3)
          FUNCT3_ADD_SUB: begin legal = 1'b1; alu_op = ALU_ADD; end
          FUNCT3_AND:     begin legal = 1'b1; alu_op = ALU_AND; end
          FUNCT3_OR:      begin legal = 1'b1; alu_op = ALU_OR;  end
          FUNCT3_XOR:     begin legal = 1'b1; alu_op = ALU_XOR; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign rs1 = instr[19:15];
  assign rd  = instr[11:7];
  assign rs2 = is_imm ? 5'd0 : instr[24:20];
  assign imm = (is_imm && legal) ? {{(cpu_pkg::XLEN-12){instr[31]}}, instr[31:20]} : '0;

  // x0 writes are dropped here so later stages never see a write enable for rd=0.
  assign ctrl = '{
    alu_op:    alu_op,
    src_a_sel: SRC_A_RS1,
    src_b_sel: src_b_sel,
    reg_write: legal && (rd != 5'd0)
  };
  assign illegal = !legal;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with a one-entry skid buffer so in_ready depends only on flops.
module decode_stage #(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instr,
  input  logic [XLEN-1:0]           in_pc,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output cpu_pkg::control_signals_t out_ctrl,
  output logic [4:0]                out_rs1,
  output logic [4:0]                out_rs2,
  output logic [4:0]                out_rd,
  output logic [XLEN-1:0]           out_imm,
  output logic                      out_illegal
);

  import cpu_pkg::*;

  control_signals_t dec_ctrl;
  logic [4:0]       dec_rs1;
  logic [4:0]       dec_rs2;
  logic [4:0]       dec_rd;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_illegal;
  decoded_bundle_t  dec;

  decoded_bundle_t  out_q, out_d;
  decoded_bundle_t  skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_xfer;
  logic             out_free;

  decode_logic u_decode_logic (
    .instr   (in_instr),
    .ctrl    (dec_ctrl),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .rd      (dec_rd),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  assign dec = '{
    pc:      in_pc,
    ctrl:    dec_ctrl,
    rs1:     dec_rs1,
    rs2:     dec_rs2,
    rd:      dec_rd,
    imm:     dec_imm,
    illegal: dec_illegal
  };

  assign in_ready = !skid_valid_q;
  assign in_xfer  = in_valid && in_ready;
  assign out_free = !out_valid_q || out_ready;

  // in_ready is low whenever skid holds data, so a skid drain never coincides with an input xfer.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_xfer;
        if (in_xfer) out_d = dec;
      end
    end else if (in_xfer) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= BUNDLE_RESET;
      skid_q       <= BUNDLE_RESET;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign out_ctrl    = out_q.ctrl;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rd      = out_q.rd;
  assign out_imm     = out_q.imm;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, back-pressure through the skid, flush and reset.
module tb_decode_stage;
  import cpu_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [31:0]      in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  control_signals_t out_ctrl;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [4:0]       out_rd;
  logic [31:0]      out_imm;
  logic             out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  decode_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_ctrl    (out_ctrl),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .out_imm     (out_imm),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle so outputs are sampled well away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic check_dec(input string tag, input alu_op_t alu, input src_b_sel_t srcb,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [31:0] imm, input logic rw, input logic ill);
    check({tag, ".valid"},   out_valid, 1'b1);
    check({tag, ".alu_op"},  out_ctrl.alu_op, alu);
    check({tag, ".src_a"},   out_ctrl.src_a_sel, SRC_A_RS1);
    check({tag, ".src_b"},   out_ctrl.src_b_sel, srcb);
    check({tag, ".rs1"},     out_rs1, rs1);
    check({tag, ".rs2"},     out_rs2, rs2);
    check({tag, ".rd"},      out_rd, rd);
    check({tag, ".imm"},     out_imm, imm);
    check({tag, ".reg_wr"},  out_ctrl.reg_write, rw);
    check({tag, ".illegal"}, out_illegal, ill);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h4031_0133, 32'h0000_0ABC);
    repeat (3) step();
    check("rst_hold.valid", out_valid, 1'b0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    check("reset.valid", out_valid, 1'b0);
    check("reset.in_ready", in_ready, 1'b1);
    check("reset.ctrl", out_ctrl, CTRL_RESET);
    check("reset.pc", out_pc, 32'h0);
    check("reset.imm", out_imm, 32'h0);

    // sub x2,x2,x3
    drive(1'b1, 32'h4031_0133, 32'h0000_0100);
    step();
    check("sub.pc", out_pc, 32'h100);
    check_dec("sub", ALU_SUB, SRC_B_RS2, 5'd2, 5'd3, 5'd2, 32'h0, 1'b1, 1'b0);

    // funct3=101 with SUB funct7 (sra x2,x2,x3) is outside the supported set
    drive(1'b1, 32'h4031_5133, 32'h0000_0104);
    step();
    check_dec("sra", ALU_NOP, SRC_B_RS2, 5'd2, 5'd3, 5'd2, 32'h0, 1'b0, 1'b1);

    // addi x1,x0,-1 : rs2 field bits are all ones but must read as 0
    drive(1'b1, 32'hFFF0_0093, 32'h0000_0108);
    step();
    check_dec("addi_m1", ALU_ADD, SRC_B_IMM, 5'd0, 5'd0, 5'd1, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // addi x0,x0,0
    drive(1'b1, 32'h0000_0013, 32'h0000_010C);
    step();
    check_dec("nop", ALU_ADD, SRC_B_IMM, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);

    // andi x1,x1,0x7f
    drive(1'b1, 32'h07F0_F093, 32'h0000_0110);
    step();
    check_dec("andi", ALU_AND, SRC_B_IMM, 5'd1, 5'd0, 5'd1, 32'h7F, 1'b1, 1'b0);

    // and x5,x6,x7
    drive(1'b1, 32'h0073_72B3, 32'h0000_0114);
    step();
    check_dec("and", ALU_AND, SRC_B_RS2, 5'd6, 5'd7, 5'd5, 32'h0, 1'b1, 1'b0);

    // lui x0,0
    drive(1'b1, 32'h0000_0037, 32'h0000_0118);
    step();
    check_dec("lui", ALU_NOP, SRC_B_RS2, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);

    // slli x0,x0,0
    drive(1'b1, 32'h0000_1013, 32'h0000_011C);
    step();
    check_dec("slli", ALU_NOP, SRC_B_IMM, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);

    drive(1'b0, 32'h0, 32'h0);
    step();
    check("idle.valid", out_valid, 1'b0);

    // Back-pressure: A, B, C with execute stalled
    out_ready = 1'b0;
    drive(1'b1, 32'h0031_00B3, 32'h0000_0200);
    step();
    check("bp_a.pc", out_pc, 32'h200);
    check("bp_a.in_ready", in_ready, 1'b1);
    drive(1'b1, 32'h0062_8233, 32'h0000_0204);
    step();
    check("bp_b.out_pc", out_pc, 32'h200);
    check("bp_b.in_ready", in_ready, 1'b0);
    drive(1'b1, 32'h0093_E3B3, 32'h0000_0208);
    step();
    check("bp_c.out_pc", out_pc, 32'h200);
    check("bp_c.valid", out_valid, 1'b1);
    check("bp_c.in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    step();
    check("drain_b.pc", out_pc, 32'h204);
    check("drain_b.rd", out_rd, 5'd4);
    check("drain_b.in_ready", in_ready, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("drain_c.pc", out_pc, 32'h208);
    check("drain_c.rd", out_rd, 5'd7);
    check("drain_c.alu", out_ctrl.alu_op, ALU_OR);
    step();
    check("drain_end.valid", out_valid, 1'b0);

    // Flush with out and skid both full
    out_ready = 1'b0;
    drive(1'b1, 32'h0031_00B3, 32'h0000_0300);
    step();
    drive(1'b1, 32'h0031_00B3, 32'h0000_0304);
    step();
    check("pre_flush.in_ready", in_ready, 1'b0);
    drive(1'b1, 32'h0031_00B3, 32'h0000_0308);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush.valid", out_valid, 1'b0);
    check("flush.in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    step();
    check("post_flush.valid", out_valid, 1'b0);

    // Flush drops an input accepted in the same cycle
    drive(1'b1, 32'h0031_00B3, 32'h0000_0400);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush_in.valid", out_valid, 1'b0);
    step();
    check("flush_in2.valid", out_valid, 1'b0);

    // Reset beats flush and clears all stored state
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF0_0093, 32'h0000_0500);
    step();
    step();
    rst   = 1'b1;
    flush = 1'b1;
    step();
    rst   = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    check("rst_flush.valid", out_valid, 1'b0);
    check("rst_flush.in_ready", in_ready, 1'b1);
    check("rst_flush.ctrl", out_ctrl, CTRL_RESET);
    check("rst_flush.pc", out_pc, 32'h0);
    check("rst_flush.imm", out_imm, 32'h0);
    out_ready = 1'b1;
    step();
    check("rst_flush2.valid", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
